// File: rtl/display_pkg.sv
// Shared definitions for the LED matrix display path.
//
// Contents:
//   N_ROWS / N_COLS : matrix geometry (6x6)
//   ROW_IDX_W       : width of a row index / write pointer
//   cmd_t           : command field carried in rx_data[7:6]
//   col_off()       : column value that turns every LED off for a given polarity
//   col_drive()     : maps a lit-pixel pattern onto the column pins
package display_pkg;

  localparam int N_ROWS    = 6;
  localparam int N_COLS    = 6;
  localparam int ROW_IDX_W = $clog2(N_ROWS);

  typedef enum logic [1:0] {
    CMD_SETPTR = 2'b00,
    CMD_WRITE  = 2'b01,
    CMD_CLEAR  = 2'b10,
    CMD_COMMIT = 2'b11
  } cmd_t;

  function automatic logic [N_COLS-1:0] col_off(input bit active_low);
    return active_low ? {N_COLS{1'b1}} : {N_COLS{1'b0}};
  endfunction

  function automatic logic [N_COLS-1:0] col_drive(input bit active_low,
                                                  input logic [N_COLS-1:0] pattern);
    return active_low ? ~pattern : pattern;
  endfunction

endpackage

// File: rtl/led_matrix_scan_row_scan_ctr.sv
// Row-slot timing for the LED matrix scanner.
//
// Ports:
//   clk             in   system clock
//   rst             in   asynchronous active-high reset
//   row_idx         out  row currently being scanned (0 = top)
//   display_en      out  current tick lies in the lit part of the row slot
//   frame_boundary  out  last tick of the last row slot of a frame
//   frame_start_pre out  first tick of row 0 (registered by the parent into frame_start)
//
// All status outputs are combinational from the counters; the parent registers
// whatever reaches the pins.
module row_scan_ctr
  import display_pkg::*;
#(
  parameter int ROW_TICKS   = 2000,
  parameter int BLANK_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ROW_IDX_W-1:0] row_idx,
  output logic                 display_en,
  output logic                 frame_boundary,
  output logic                 frame_start_pre
);

  localparam int TICK_W = (ROW_TICKS > 1) ? $clog2(ROW_TICKS) : 1;
  localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(ROW_TICKS - 1);
  localparam logic [TICK_W-1:0]    DISP_END  = TICK_W'(ROW_TICKS - BLANK_TICKS);
  localparam logic [ROW_IDX_W-1:0] ROW_LAST  = ROW_IDX_W'(N_ROWS - 1);

  logic [TICK_W-1:0] tick;
  logic              run;

  // The scan is held for one clock after reset release so that the first lit
  // row appears on the second rising edge; this also gives the release a full
  // cycle to settle before any counter moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  // tick walks through one row slot; row_idx steps once per slot and wraps
  // after the bottom row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick    <= '0;
      row_idx <= '0;
    end else if (run) begin
      if (tick == TICK_LAST) begin
        tick    <= '0;
        row_idx <= (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

  assign display_en      = run && (tick < DISP_END);
  assign frame_boundary  = run && (tick == TICK_LAST) && (row_idx == ROW_LAST);
  assign frame_start_pre = run && (tick == '0) && (row_idx == '0);

endmodule

// File: rtl/led_matrix_scan.sv
// LED matrix scanner: consumes command bytes from the UART receiver, builds a
// shadow frame, swaps it into the displayed frame at frame boundaries and
// time-multiplexes the 6 rows with a blanking gap between row slots.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   rx_data[7:0]   in   received byte: [7:6] command, [5:0] payload
//   rx_valid       in   one-cycle strobe qualifying rx_data
//   row[5:0]       out  one-hot row enable, bit 0 = top row
//   col[5:0]       out  column drive for the enabled row
//   frame_start    out  one-cycle pulse as row 0 lights for a new frame
//   commit_pending out  a COMMIT is waiting for the next frame boundary
module led_matrix_scan
  import display_pkg::*;
#(
  parameter int ROW_TICKS      = 2000,
  parameter int BLANK_TICKS    = 16,
  parameter int COL_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [N_ROWS-1:0] row,
  output logic [N_COLS-1:0] col,
  output logic              frame_start,
  output logic              commit_pending
);

  localparam bit                  ACTIVE_LOW = (COL_ACTIVE_LOW != 0);
  localparam logic [N_COLS-1:0]   COL_OFF    = col_off(ACTIVE_LOW);
  localparam logic [ROW_IDX_W-1:0] PTR_LAST  = ROW_IDX_W'(N_ROWS - 1);

  logic [ROW_IDX_W-1:0] row_idx;
  logic                 display_en;
  logic                 frame_boundary;
  logic                 frame_start_pre;

  logic [N_COLS-1:0]    shadow [N_ROWS];
  logic [N_COLS-1:0]    active [N_ROWS];
  logic [ROW_IDX_W-1:0] ptr;

  cmd_t                 cmd;
  logic [N_ROWS-1:0]    row_onehot;

  assign cmd        = cmd_t'(rx_data[7:6]);
  assign row_onehot = {{(N_ROWS-1){1'b0}}, 1'b1} << row_idx;

  row_scan_ctr #(
    .ROW_TICKS   (ROW_TICKS),
    .BLANK_TICKS (BLANK_TICKS)
  ) u_row_scan_ctr (
    .clk             (clk),
    .rst             (rst),
    .row_idx         (row_idx),
    .display_en      (display_en),
    .frame_boundary  (frame_boundary),
    .frame_start_pre (frame_start_pre)
  );

  // Command decode into the shadow frame. SETPTR values past the last row are
  // dropped rather than clamped so a corrupted byte cannot move the pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ROWS; i++) begin
        shadow[i] <= '0;
      end
      ptr <= '0;
    end else if (rx_valid) begin
      case (cmd)
        CMD_SETPTR: begin
          if (rx_data[ROW_IDX_W-1:0] <= PTR_LAST) begin
            ptr <= rx_data[ROW_IDX_W-1:0];
          end
        end
        CMD_WRITE: begin
          shadow[ptr] <= rx_data[N_COLS-1:0];
          ptr         <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
        CMD_CLEAR: begin
          for (int i = 0; i < N_ROWS; i++) begin
            shadow[i] <= '0;
          end
          ptr <= '0;
        end
        default: ;
      endcase
    end
  end

  // Commit handshake. The swap copies the shadow as registered at the start of
  // the boundary cycle, so a same-cycle WRITE/CLEAR misses this frame. A COMMIT
  // on the boundary is ordered after the clear and re-arms for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ROWS; i++) begin
        active[i] <= '0;
      end
      commit_pending <= 1'b0;
    end else begin
      if (frame_boundary && commit_pending) begin
        active         <= shadow;
        commit_pending <= 1'b0;
      end
      if (rx_valid && (cmd == CMD_COMMIT)) begin
        commit_pending <= 1'b1;
      end
    end
  end

  // Pin registers: rows and columns are both forced off during blanking so the
  // next row never sees the previous row's column pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row         <= '0;
      col         <= COL_OFF;
      frame_start <= 1'b0;
    end else begin
      row         <= display_en ? row_onehot : '0;
      col         <= display_en ? col_drive(ACTIVE_LOW, active[row_idx]) : COL_OFF;
      frame_start <= frame_start_pre;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
`timescale 1ns/1ps
// Randomised self-checking bench for led_matrix_scan. The reference model
// predicts the pins from the number of clock edges since reset release and a
// plain array picture of the shadow/active frames.
module tb_led_matrix_scan;

  localparam int RT    = 20;
  localparam int BT    = 2;
  localparam int FRAME = RT * 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [5:0] row;
  logic [5:0] col;
  logic       frame_start;
  logic       commit_pending;

  int vectors = 0;
  int miscompares = 0;

  logic [5:0] m_shadow [6];
  logic [5:0] m_active [6];
  int         m_ptr;
  bit         m_pending;
  int         k;

  logic [5:0] exp_row;
  logic [5:0] exp_col;
  logic       exp_fs;
  logic       exp_pending;

  led_matrix_scan #(
    .ROW_TICKS      (RT),
    .BLANK_TICKS    (BT),
    .COL_ACTIVE_LOW (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .row            (row),
    .col            (col),
    .frame_start    (frame_start),
    .commit_pending (commit_pending)
  );

  always #41.667 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 6; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_ptr     = 0;
    m_pending = 0;
    k         = 0;
  endtask

  // Edge number k (1 = first edge after release) shows scan position k-2.
  task automatic modelEdge();
    int q, slot, inner;
    bit boundary;
    if (rst) begin
      modelReset();
      exp_row = '0; exp_col = 6'h3F; exp_fs = 0; exp_pending = 0;
      return;
    end
    k++;
    boundary = 0;
    if (k >= 2) begin
      q     = k - 2;
      slot  = (q / RT) % 6;
      inner = q % RT;
      if (inner < RT - BT) begin
        exp_row = 6'(1 << slot);
        exp_col = ~m_active[slot];
      end else begin
        exp_row = '0;
        exp_col = 6'h3F;
      end
      exp_fs   = (q % FRAME) == 0;
      boundary = (q % FRAME) == FRAME - 1;
    end else begin
      exp_row = '0; exp_col = 6'h3F; exp_fs = 0;
    end
    if (boundary && m_pending) begin
      for (int i = 0; i < 6; i++) m_active[i] = m_shadow[i];
      m_pending = 0;
    end
    if (rx_valid) begin
      case (rx_data[7:6])
        2'b00: if (rx_data[2:0] < 6) m_ptr = int'(rx_data[2:0]);
        2'b01: begin
          m_shadow[m_ptr] = rx_data[5:0];
          m_ptr = (m_ptr + 1) % 6;
        end
        2'b10: begin
          for (int i = 0; i < 6; i++) m_shadow[i] = '0;
          m_ptr = 0;
        end
        default: m_pending = 1;
      endcase
    end
    exp_pending = m_pending;
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk);
    rst = r; rx_valid = v; rx_data = d;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("row",            {2'b0, row},            {2'b0, exp_row});
    checkOutput("col",            {2'b0, col},            {2'b0, exp_col});
    checkOutput("frame_start",    {7'b0, frame_start},    {7'b0, exp_fs});
    checkOutput("commit_pending", {7'b0, commit_pending}, {7'b0, exp_pending});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] d);
    applyStimulus(1'b0, 1'b1, d);
    idle(2);
  endtask

  function automatic bit nextIsBoundary();
    return (k + 1 >= 2) && ((k - 1) % FRAME == FRAME - 1);
  endfunction

  // Idle until the next clock edge is the frame boundary.
  task automatic waitBoundary();
    for (int i = 0; i < 2 * FRAME && !nextIsBoundary(); i++) idle(1);
    checkOutput("boundary_reached", {7'b0, nextIsBoundary()}, 8'd1);
  endtask

  // Idle until the most recent edge showed scan position pos within a frame.
  task automatic waitPos(input int pos);
    for (int i = 0; i < 2 * FRAME && !(k >= 2 && (k - 2) % FRAME == pos); i++) idle(1);
    checkOutput("position_reached", {7'b0, (k >= 2 && (k - 2) % FRAME == pos)}, 8'd1);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
    modelReset();

    // Reset and free-running scan with an empty frame.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'($urandom));
    idle(2 * FRAME + 5);

    // Two rows written, then committed.
    send(8'h42); send(8'h43); send(8'hC0);
    waitBoundary(); idle(FRAME + 3);

    // Pointer wrap from row 5 to row 0.
    send(8'h05); send(8'h7F); send(8'h41); send(8'hC0);
    waitBoundary(); idle(FRAME + 3);

    // Out-of-range SETPTR leaves the pointer alone.
    send(8'h03); send(8'h07); send(8'h41); send(8'hC0);
    waitBoundary(); idle(FRAME + 3);

    // COMMIT on the boundary cycle waits for the following boundary.
    send(8'h00); send(8'h6A);
    waitBoundary(); applyStimulus(1'b0, 1'b1, 8'hC0);
    idle(FRAME + 3);

    // WRITE on a boundary with a commit pending is not included.
    send(8'hC0); send(8'h80);
    waitBoundary(); applyStimulus(1'b0, 1'b1, 8'h55);
    idle(FRAME + 3);

    // Random command stream, with some commands forced onto boundaries.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        waitBoundary();
        applyStimulus(1'b0, 1'b1, 8'($urandom));
      end else begin
        applyStimulus(1'b0, 1'b1, 8'($urandom));
        idle($urandom_range(1, 40));
      end
    end
    idle(FRAME + 3);

    // Asynchronous reset in the middle of row 3 with a commit pending.
    send(8'h3F); send(8'h3F);
    waitPos(60); applyStimulus(1'b0, 1'b1, 8'hC0);
    waitPos(70);
    #5 rst = 1'b1;
    #1;
    checkOutput("async_row",     {2'b0, row},            8'h00);
    checkOutput("async_col",     {2'b0, col},            8'h3F);
    checkOutput("async_pending", {7'b0, commit_pending}, 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h00);
    idle(FRAME + 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
